hamming_secded_decoder: RTL and testbench

- Hardware engine for the program-2 direction of the Hamming SECDED scheme: reads 15 possibly corrupted 16-bit codewords from data memory, recovers each 11-bit message and writes it back with a status tag.
- It is the decoder counterpart of the program-1 parity inserter.
- Sits beside the data memory on its single read/write port.
- Started by a req pulse; signals completion with an ack pulse, the same handshake the top level uses.

---
 rtl/hamming_secded_decoder_if.sv | 50 +++++
 rtl/hamming_secded_decoder.sv | 162 ++++++++++++++++
 tb/tb_hamming_secded_decoder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_secded_decoder_if.sv
// Bus bundle for the SECDED decoder engine.
// Carries the start/completion handshake, the run statistics and the single
// read/write port of the data memory.
//   req          start request (into engine)
//   ack          one-cycle completion pulse
//   busy         engine running
//   n_corrected  single-error words seen in the last run
//   n_double     double-error words seen in the last run
//   mem_addr     memory byte address
//   mem_rd_data  synchronous read data (valid one cycle after mem_addr)
//   mem_wr_en    write strobe
//   mem_wr_data  write data
// Modport slave is the engine side, master is the controller/memory side.
interface hamming_secded_decoder_if #(
    parameter int ADDR_W = 8
);
    logic              req;
    logic              ack;
    logic              busy;
    logic [7:0]        n_corrected;
    logic [7:0]        n_double;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;

    modport slave (
        input  req,
        input  mem_rd_data,
        output ack,
        output busy,
        output n_corrected,
        output n_double,
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data
    );

    modport master (
        output req,
        output mem_rd_data,
        input  ack,
        input  busy,
        input  n_corrected,
        input  n_double,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data
    );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Hamming SECDED decoder engine.
// Reads NUM_WORDS 16-bit codewords (low byte first) from SRC_BASE, corrects
// single errors, flags double errors, and writes each 11-bit message plus a
// 2-bit status tag to DST_BASE as two bytes.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    hamming_secded_decoder_if.slave (handshake, stats, memory port)
//
// state | meaning
// IDLE  | waiting for req
// RD_LO | present codeword low-byte address
// RD_HI | present high-byte address, capture low byte
// CAP   | capture high byte
// WR_LO | write result low byte, update error counters
// WR_HI | write result high byte, advance or finish
// DONE  | one-cycle ack
module hamming_secded_decoder #(
    parameter int SRC_BASE  = 64,
    parameter int DST_BASE  = 94,
    parameter int NUM_WORDS = 15,
    parameter int ADDR_W    = 8
) (
    input  logic clk,
    input  logic reset,
    hamming_secded_decoder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        CAP,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [6:0]        idx;
    logic [15:0]       cw;
    logic [7:0]        n_corr;
    logic [7:0]        n_dbl;

    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic              last_word;

    logic [3:0]        syn;
    logic              pall;
    logic [15:0]       cw_fix;
    logic [1:0]        status;
    logic [7:0]        res_lo;
    logic [7:0]        res_hi;
    logic              err_single;
    logic              err_double;

    // Address arithmetic deliberately wraps modulo 2^ADDR_W.
    assign src_addr  = ADDR_W'(SRC_BASE + 2 * int'(idx));
    assign dst_addr  = ADDR_W'(DST_BASE + 2 * int'(idx));
    assign last_word = (idx == 7'(NUM_WORDS - 1));

    always_comb begin
        syn = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (cw[k]) syn = syn ^ 4'(k);
        end
        pall       = ^cw;
        err_single = pall;
        err_double = !pall && (syn != 4'd0);
        cw_fix     = cw;
        // syn==0 with odd parity lands on bit 0 (p16), leaving data untouched.
        if (err_single) cw_fix[syn] = ~cw[syn];
        status     = {err_double, err_single};
        res_lo     = {cw_fix[12:9], cw_fix[7:5], cw_fix[3]};
        res_hi     = {status, 3'b000, cw_fix[15:13]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            idx    <= 7'd0;
            cw     <= 16'd0;
            n_corr <= 8'd0;
            n_dbl  <= 8'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        idx    <= 7'd0;
                        n_corr <= 8'd0;
                        n_dbl  <= 8'd0;
                    end
                end
                RD_HI: cw[7:0]  <= bus.mem_rd_data;
                CAP:   cw[15:8] <= bus.mem_rd_data;
                WR_LO: begin
                    if (err_single && n_corr != 8'hFF) n_corr <= n_corr + 8'd1;
                    if (err_double && n_dbl != 8'hFF)  n_dbl  <= n_dbl + 8'd1;
                end
                WR_HI: begin
                    if (!last_word) idx <= idx + 7'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.ack         = 1'b0;
        bus.busy        = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = 8'd0;
        case (state)
            IDLE: begin
                if (bus.req) state_nxt = RD_LO;
            end
            RD_LO: begin
                bus.busy     = 1'b1;
                bus.mem_addr = src_addr;
                state_nxt    = RD_HI;
            end
            RD_HI: begin
                bus.busy     = 1'b1;
                bus.mem_addr = src_addr + ADDR_W'(1);
                state_nxt    = CAP;
            end
            CAP: begin
                bus.busy  = 1'b1;
                state_nxt = WR_LO;
            end
            WR_LO: begin
                bus.busy        = 1'b1;
                bus.mem_addr    = dst_addr;
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_data = res_lo;
                state_nxt       = WR_HI;
            end
            WR_HI: begin
                bus.busy        = 1'b1;
                bus.mem_addr    = dst_addr + ADDR_W'(1);
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_data = res_hi;
                state_nxt       = last_word ? DONE : RD_LO;
            end
            DONE: begin
                bus.busy  = 1'b1;
                bus.ack   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.n_corrected = n_corr;
    assign bus.n_double    = n_dbl;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
module tb_hamming_secded_decoder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hamming_secded_decoder_if #(.ADDR_W(8)) bus ();

    hamming_secded_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    int n_wr;
    int n_bad_wr;
    int n_ack;
    int n_pass;
    int n_total;

    // Synchronous memory model plus write/ack monitor.
    always @(posedge clk) begin
        bus.mem_rd_data <= mem[bus.mem_addr];
        if (bus.mem_wr_en) begin
            mem[bus.mem_addr] = bus.mem_wr_data;
            n_wr++;
            if (bus.mem_addr < 8'd94 || bus.mem_addr > 8'd123) n_bad_wr++;
        end
        if (bus.ack) n_ack++;
    end

    function automatic logic [15:0] enc(input logic [10:0] d);
        logic [15:0] c;
        logic [3:0]  s;
        c       = 16'd0;
        c[3]    = d[0];
        c[7:5]  = d[3:1];
        c[15:9] = d[10:4];
        s       = 4'd0;
        for (int k = 1; k < 16; k++) if (c[k]) s = s ^ 4'(k);
        c[1] = s[0];
        c[2] = s[1];
        c[4] = s[2];
        c[8] = s[3];
        c[0] = ^c[15:1];
        return c;
    endfunction

    task automatic prep();
        for (int i = 0; i < 256; i++) mem[i] = 8'hA5;
        for (int i = 0; i < 15; i++) begin
            mem[64 + 2*i]     = 8'h00;
            mem[64 + 2*i + 1] = 8'h00;
        end
        n_wr = 0;
        n_bad_wr = 0;
        n_ack = 0;
    endtask

    task automatic put_cw(input int i, input logic [15:0] c);
        mem[64 + 2*i]     = c[7:0];
        mem[64 + 2*i + 1] = c[15:8];
    endtask

    task automatic run_job(output int cyc);
        @(negedge clk);
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        cyc = 1;
        while (bus.ack !== 1'b1 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.ack !== 1'b0) $display("FAIL reset_ack got %0b want 0", bus.ack); else n_pass++;
        n_total++; if (bus.mem_wr_en !== 1'b0) $display("FAIL reset_wr_en got %0b want 0", bus.mem_wr_en); else n_pass++;
        n_total++; if (bus.mem_addr !== 8'd0) $display("FAIL reset_addr got %0h want 0", bus.mem_addr); else n_pass++;
        n_total++; if (bus.n_corrected !== 8'd0) $display("FAIL reset_ncorr got %0d want 0", bus.n_corrected); else n_pass++;
        n_total++; if (bus.n_double !== 8'd0) $display("FAIL reset_ndbl got %0d want 0", bus.n_double); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got %0b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_clean();
        int cyc;
        prep();
        run_job(cyc);
        n_total++; if (mem[94] !== 8'h00) $display("FAIL clean_lo got %0h want 00", mem[94]); else n_pass++;
        n_total++; if (mem[95] !== 8'h00) $display("FAIL clean_hi got %0h want 00", mem[95]); else n_pass++;
        n_total++; if (bus.n_corrected !== 8'd0) $display("FAIL clean_ncorr got %0d want 0", bus.n_corrected); else n_pass++;
        n_total++; if (bus.n_double !== 8'd0) $display("FAIL clean_ndbl got %0d want 0", bus.n_double); else n_pass++;
    endtask

    task automatic test_single();
        int cyc;
        prep();
        put_cw(0, 16'hFFBF);
        run_job(cyc);
        n_total++; if (mem[94] !== 8'hFF) $display("FAIL single_lo got %0h want ff", mem[94]); else n_pass++;
        n_total++; if (mem[95] !== 8'h47) $display("FAIL single_hi got %0h want 47", mem[95]); else n_pass++;
        n_total++; if (bus.n_corrected !== 8'd1) $display("FAIL single_ncorr got %0d want 1", bus.n_corrected); else n_pass++;
    endtask

    task automatic test_p16();
        int cyc;
        prep();
        put_cw(3, 16'hFFFE);
        run_job(cyc);
        n_total++; if (mem[100] !== 8'hFF) $display("FAIL p16_lo got %0h want ff", mem[100]); else n_pass++;
        n_total++; if (mem[101] !== 8'h47) $display("FAIL p16_hi got %0h want 47", mem[101]); else n_pass++;
        n_total++; if (bus.n_corrected !== 8'd1) $display("FAIL p16_ncorr got %0d want 1", bus.n_corrected); else n_pass++;
    endtask

    task automatic test_double();
        int cyc;
        prep();
        put_cw(0, 16'h0208);
        run_job(cyc);
        n_total++; if (mem[94] !== 8'h11) $display("FAIL double_lo got %0h want 11", mem[94]); else n_pass++;
        n_total++; if (mem[95] !== 8'h80) $display("FAIL double_hi got %0h want 80", mem[95]); else n_pass++;
        n_total++; if (bus.n_double !== 8'd1) $display("FAIL double_ndbl got %0d want 1", bus.n_double); else n_pass++;
        n_total++; if (bus.n_corrected !== 8'd0) $display("FAIL double_ncorr got %0d want 0", bus.n_corrected); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [10:0] d [15];
        logic [15:0] c;
        prep();
        for (int i = 0; i < 15; i++) begin
            d[i] = 11'((i * 16'h2A5 + 16'h13) & 16'h7FF);
            c = enc(d[i]);
            c[(i * 7) % 16] = ~c[(i * 7) % 16];
            put_cw(i, c);
        end
        @(negedge clk);
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        cyc = 1;
        while (bus.ack !== 1'b1 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.req = (cyc == 20 || cyc == 74);
        end
        bus.req = 1'b0;
        n_total++; if (cyc !== 76) $display("FAIL latency got %0d want 76", cyc); else n_pass++;
        for (int i = 0; i < 15; i++) begin
            n_total++;
            if (mem[94 + 2*i] !== d[i][7:0])
                $display("FAIL word%0d_lo got %0h want %0h", i, mem[94 + 2*i], d[i][7:0]);
            else n_pass++;
            n_total++;
            if (mem[95 + 2*i] !== {2'b01, 3'b000, d[i][10:8]})
                $display("FAIL word%0d_hi got %0h want %0h", i, mem[95 + 2*i], {2'b01, 3'b000, d[i][10:8]});
            else n_pass++;
        end
        repeat (4) @(posedge clk);
        #1;
        n_total++; if (n_ack !== 1) $display("FAIL ack_count got %0d want 1", n_ack); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL req_not_queued busy got %0b want 0", bus.busy); else n_pass++;
        n_total++; if (n_bad_wr !== 0) $display("FAIL bad_writes got %0d want 0", n_bad_wr); else n_pass++;
        n_total++; if (n_wr !== 30) $display("FAIL write_count got %0d want 30", n_wr); else n_pass++;
        n_total++; if (bus.n_corrected !== 8'd15) $display("FAIL rand_ncorr got %0d want 15", bus.n_corrected); else n_pass++;
        n_total++; if (bus.n_double !== 8'd0) $display("FAIL rand_ndbl got %0d want 0", bus.n_double); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        logic [10:0] d [15];
        prep();
        for (int i = 0; i < 15; i++) begin
            d[i] = 11'((i * 16'h111 + 16'h5) & 16'h7FF);
            put_cw(i, enc(d[i]));
        end
        @(negedge clk);
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        repeat (36) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %0b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.ack !== 1'b0) $display("FAIL abort_ack got %0b want 0", bus.ack); else n_pass++;
        n_total++; if (bus.mem_wr_en !== 1'b0) $display("FAIL abort_wr_en got %0b want 0", bus.mem_wr_en); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (mem[107] !== {2'b00, 3'b000, d[6][10:8]}) $display("FAIL abort_word6 got %0h want %0h", mem[107], {2'b00, 3'b000, d[6][10:8]}); else n_pass++;
        for (int a = 108; a < 124; a++) begin
            n_total++;
            if (mem[a] !== 8'hA5) $display("FAIL abort_untouched[%0d] got %0h want a5", a, mem[a]);
            else n_pass++;
        end
        @(negedge clk);
        reset = 1'b1;
        run_job(cyc);
        n_total++; if (cyc !== 76) $display("FAIL rerun_latency got %0d want 76", cyc); else n_pass++;
        for (int i = 0; i < 15; i++) begin
            n_total++;
            if ({mem[95 + 2*i], mem[94 + 2*i]} !== {5'b00000, d[i]})
                $display("FAIL rerun_word%0d got %0h want %0h", i, {mem[95 + 2*i], mem[94 + 2*i]}, {5'b00000, d[i]});
            else n_pass++;
        end
        n_total++; if (bus.n_corrected !== 8'd0) $display("FAIL rerun_ncorr got %0d want 0", bus.n_corrected); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        n_wr = 0;
        n_bad_wr = 0;
        n_ack = 0;
        bus.req = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_clean();
        test_single();
        test_p16();
        test_double();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
